iatan2_cordic: RTL

- Inverse of the integer sine/cosine blocks: takes a signed 16-bit vector (x, y) and returns its angle atan2(y, x) in Furmans.
- A Furman is 1/65536 circle; the output is 16-bit modulo 65536, read as signed -32768..32767.
- Also returns the CORDIC-gained magnitude.
- Iterative vectoring-mode CORDIC, one micro-rotation per clock, valid/ready on both sides; sits between sensor/vector sources and heading/steering logic.

---
 rtl/iatan2_pkg.sv | 26 ++
 rtl/iatan2_cordic_if.sv | 24 ++
 rtl/iatan2_stage.sv | 36 +++
 rtl/iatan2_cordic.sv | 127 ++++++++++++
 4 files changed

// File: rtl/iatan2_pkg.sv
// Shared constants for the iatan2 vectoring CORDIC: widths, FSM encoding and
// the arctangent table in Furmans (1/65536 of a circle).
package iatan2_pkg;

  localparam int unsigned IN_W     = 16;
  localparam int unsigned ANG_W    = 16;
  localparam int unsigned MAG_W    = 17;
  localparam int unsigned XW_DEF   = 18;
  localparam int unsigned ITER_MAX = 14;
  localparam int unsigned CNT_W    = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [ANG_W-1:0] HALF_TURN = 16'h8000;

  // atan(2^-i) in Furmans; element 0 is the rightmost entry
  localparam logic [ITER_MAX-1:0][ANG_W-1:0] ATAN_TAB = {
    16'd1,    16'd3,    16'd5,    16'd10,   16'd20,   16'd41,   16'd81,
    16'd163,  16'd326,  16'd651,  16'd1297, 16'd2555, 16'd4836, 16'd8192
  };

endpackage

// File: rtl/iatan2_cordic_if.sv
// Valid/ready input vector and result channels of the iatan2 CORDIC.
interface iatan2_cordic_if;
  import iatan2_pkg::*;

  logic                    in_valid;
  logic                    in_ready;
  logic signed [IN_W-1:0]  in_x;
  logic signed [IN_W-1:0]  in_y;
  logic                    out_valid;
  logic                    out_ready;
  logic [ANG_W-1:0]        out_angle;
  logic [MAG_W-1:0]        out_mag;

  modport master (
    output in_valid, in_x, in_y, out_ready,
    input  in_ready, out_valid, out_angle, out_mag
  );

  modport slave (
    input  in_valid, in_x, in_y, out_ready,
    output in_ready, out_valid, out_angle, out_mag
  );

endinterface

// File: rtl/iatan2_stage.sv
// One combinational vectoring micro-rotation: drives y toward zero and
// accumulates the rotated angle in z.
module iatan2_stage
  import iatan2_pkg::*;
#(
  parameter int unsigned XW = XW_DEF
) (
  input  logic signed [XW-1:0] x_i,
  input  logic signed [XW-1:0] y_i,
  input  logic [ANG_W-1:0]     z_i,
  input  logic [CNT_W-1:0]     shift_i,
  input  logic [ANG_W-1:0]     atan_i,
  output logic signed [XW-1:0] x_o,
  output logic signed [XW-1:0] y_o,
  output logic [ANG_W-1:0]     z_o
);

  logic signed [XW-1:0] xs;
  logic signed [XW-1:0] ys;

  assign xs = x_i >>> shift_i;
  assign ys = y_i >>> shift_i;

  always_comb begin
    if (!y_i[XW-1]) begin
      x_o = x_i + ys;
      y_o = y_i - xs;
      z_o = z_i + atan_i;
    end else begin
      x_o = x_i - ys;
      y_o = y_i + xs;
      z_o = z_i - atan_i;
    end
  end

endmodule

// File: rtl/iatan2_cordic.sv
// Iterative atan2/magnitude CORDIC: one micro-rotation per clock between an
// input vector handshake and a held result handshake.
module iatan2_cordic
  import iatan2_pkg::*;
#(
  parameter int unsigned ITER = 14,
  parameter int unsigned XW   = XW_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  iatan2_cordic_if.slave bus
);

  state_e               state_q, state_d;
  logic signed [XW-1:0] x_q, x_d, y_q, y_d;
  logic [ANG_W-1:0]     z_q, z_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;
  logic [ANG_W-1:0]     out_angle_q, out_angle_d;
  logic [MAG_W-1:0]     out_mag_q, out_mag_d;

  logic                 accept_c;
  logic                 last_c;
  logic signed [XW-1:0] x_ext, y_ext;
  logic signed [XW-1:0] st_x, st_y;
  logic [ANG_W-1:0]     st_z;

  assign accept_c = (state_q == ST_IDLE) && in_ready_q && bus.in_valid;
  assign last_c   = (cnt_q == CNT_W'(ITER - 1));
  assign x_ext    = {{(XW-IN_W){bus.in_x[IN_W-1]}}, bus.in_x};
  assign y_ext    = {{(XW-IN_W){bus.in_y[IN_W-1]}}, bus.in_y};

  iatan2_stage #(.XW(XW)) u_stage (
    .x_i     (x_q),
    .y_i     (y_q),
    .z_i     (z_q),
    .shift_i (cnt_q),
    .atan_i  (ATAN_TAB[cnt_q]),
    .x_o     (st_x),
    .y_o     (st_y),
    .z_o     (st_z)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept_c)      state_d = ST_RUN;
      ST_RUN:  if (last_c)        state_d = ST_DONE;
      ST_DONE: if (bus.out_ready) state_d = ST_IDLE;
      default:                    state_d = ST_IDLE;
    endcase
  end

  // Datapath and registered-output next values
  always_comb begin
    x_d         = x_q;
    y_d         = y_q;
    z_d         = z_q;
    cnt_d       = cnt_q;
    out_angle_d = out_angle_q;
    out_mag_d   = out_mag_q;
    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
    unique case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          // Left half-plane vectors are pre-rotated by 180 degrees
          if (bus.in_x[IN_W-1]) begin
            x_d = -x_ext;
            y_d = -y_ext;
            z_d = HALF_TURN;
          end else begin
            x_d = x_ext;
            y_d = y_ext;
            z_d = '0;
          end
          cnt_d = '0;
        end
      end
      ST_RUN: begin
        x_d   = st_x;
        y_d   = st_y;
        z_d   = st_z;
        cnt_d = cnt_q + CNT_W'(1);
        if (last_c) begin
          out_angle_d = st_z;
          out_mag_d   = st_x[MAG_W-1:0];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_angle_q <= '0;
      out_mag_q   <= '0;
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      z_q         <= z_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_angle_q <= out_angle_d;
      out_mag_q   <= out_mag_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_angle = out_angle_q;
  assign bus.out_mag   = out_mag_q;

endmodule
